// File: rtl/mult_result_acc.sv
// mult_result_acc: accumulates groups of N_ACC booth_mult products into a guarded signed sum
// presented on a valid/ready output, counting products dropped while back-pressured.
module mult_result_acc #(
  parameter int D_IN = 8,
  parameter int N_ACC = 4,
  parameter int GUARD = 8,
  localparam int PW = 2 * D_IN,
  localparam int ACC_W = PW + GUARD,
  localparam int CW = $clog2(N_ACC) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_in,
  input  logic [PW-1:0]    m_in,
  input  logic             clear,
  output logic [ACC_W-1:0] sum_out,
  output logic             ovf_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CW-1:0]    prod_cnt,
  output logic [7:0]       drop_cnt
);
  typedef enum logic {ACC, WAIT_OUT} state_t;
  localparam logic [CW-1:0] LAST = CW'(N_ACC - 1);
  state_t state, state_n;
  logic [ACC_W-1:0] acc, acc_n, ext, acc_next, sum_n;
  logic [CW-1:0] cnt_n;
  logic [7:0] drop_n;
  logic done_q, grp_ovf, govf_n, ovf_n, valid_n, cap, add_ovf, out_free;
  assign cap = done_in & ~done_q;
  assign ext = {{GUARD{m_in[PW-1]}}, m_in};
  assign acc_next = acc + ext;
  assign add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (acc_next[ACC_W-1] != acc[ACC_W-1]);
  assign out_free = ~sum_valid | sum_ready;
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = prod_cnt;
    govf_n = grp_ovf;
    sum_n = sum_out;
    ovf_n = ovf_out;
    valid_n = sum_valid & ~sum_ready;
    drop_n = drop_cnt;
    if (clear) begin
      acc_n = '0;
      cnt_n = '0;
      govf_n = 1'b0;
      state_n = ACC;
    end else if (state == ACC) begin
      if (cap && prod_cnt == LAST && out_free) begin
        sum_n = acc_next;
        ovf_n = grp_ovf | add_ovf;
        valid_n = 1'b1;
        acc_n = '0;
        cnt_n = '0;
        govf_n = 1'b0;
      end else if (cap) begin
        acc_n = acc_next;
        cnt_n = prod_cnt + 1'b1;
        govf_n = grp_ovf | add_ovf;
        state_n = prod_cnt == LAST ? WAIT_OUT : ACC;
      end
    end else begin
      drop_n = cap && drop_cnt != 8'hff ? drop_cnt + 8'd1 : drop_cnt;
      if (out_free) begin
        sum_n = acc;
        ovf_n = grp_ovf;
        valid_n = 1'b1;
        acc_n = '0;
        cnt_n = '0;
        govf_n = 1'b0;
        state_n = ACC;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc <= '0;
      prod_cnt <= '0;
      grp_ovf <= 1'b0;
      sum_out <= '0;
      ovf_out <= 1'b0;
      sum_valid <= 1'b0;
      drop_cnt <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      prod_cnt <= cnt_n;
      grp_ovf <= govf_n;
      sum_out <= sum_n;
      ovf_out <= ovf_n;
      sum_valid <= valid_n;
      drop_cnt <= drop_n;
      done_q <= done_in;
    end
  end
endmodule

// File: tb/tb_mult_result_acc.sv
// tb_mult_result_acc: directed checks of mult_result_acc with default guard and a GUARD=1 instance.
module tb_mult_result_acc;
  logic clk = 0, rst = 1, done_in = 0, clear = 0, sum_ready = 1;
  logic [15:0] m_in = '0;
  logic [23:0] sum0;
  logic [16:0] sum1;
  logic ovf0, ovf1, val0, val1;
  logic [2:0] cnt0, cnt1;
  logic [7:0] drop0, drop1;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  mult_result_acc u_dut (.clk(clk), .rst(rst), .done_in(done_in), .m_in(m_in), .clear(clear),
    .sum_out(sum0), .ovf_out(ovf0), .sum_valid(val0), .sum_ready(sum_ready),
    .prod_cnt(cnt0), .drop_cnt(drop0));
  mult_result_acc #(.GUARD(1)) u_g1 (.clk(clk), .rst(rst), .done_in(done_in), .m_in(m_in), .clear(clear),
    .sum_out(sum1), .ovf_out(ovf1), .sum_valid(val1), .sum_ready(sum_ready),
    .prod_cnt(cnt1), .drop_cnt(drop1));
  typedef struct {
    logic [3:0][15:0] m;
    int hold;
    logic [23:0] sum;
    logic ovf;
    logic [16:0] sum1;
    logic ovf1;
  } vec_t;
  vec_t v[6];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [15:0] m);
    done_in = 1;
    m_in = m;
    tick();
    done_in = 0;
    tick();
  endtask
  initial begin
    v[0] = '{m: {16'h4000, 16'hC080, 16'hFFFF, 16'h0001}, hold: 1, sum: 24'h000080, ovf: 0, sum1: 17'h00080, ovf1: 0};
    v[1] = '{m: {16'h4000, 16'h4000, 16'h4000, 16'h4000}, hold: 1, sum: 24'h010000, ovf: 0, sum1: 17'h10000, ovf1: 1};
    v[2] = '{m: {16'h0001, 16'h0001, 16'h0001, 16'h0001}, hold: 1, sum: 24'h000004, ovf: 0, sum1: 17'h00004, ovf1: 0};
    v[3] = '{m: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, hold: 2, sum: 24'hFE0000, ovf: 0, sum1: 17'h00000, ovf1: 1};
    v[4] = '{m: {16'h0003, 16'h0003, 16'h0003, 16'h0003}, hold: 5, sum: 24'h00000C, ovf: 0, sum1: 17'h0000C, ovf1: 0};
    v[5] = '{m: {16'hFFFE, 16'h0001, 16'h7FFF, 16'h7FFF}, hold: 1, sum: 24'h00FFFD, ovf: 0, sum1: 17'h0FFFD, ovf1: 0};
    tick();
    tick();
    rst = 0;
    chk("reset sum", 32'(sum0), 0);
    chk("reset ovf", 32'(ovf0), 0);
    chk("reset valid", 32'(val0), 0);
    chk("reset cnt", 32'(cnt0), 0);
    chk("reset drop", 32'(drop0), 0);
    for (int g = 0; g < 6; g++) begin
      for (int k = 0; k < 4; k++) begin
        done_in = 1;
        m_in = v[g].m[k];
        tick();
        chk($sformatf("g%0d cnt%0d", g, k), 32'(cnt0), 32'((k + 1) % 4));
        if (k == 3) begin
          chk($sformatf("g%0d valid", g), 32'(val0), 1);
          chk($sformatf("g%0d sum", g), 32'(sum0), 32'(v[g].sum));
          chk($sformatf("g%0d ovf", g), 32'(ovf0), 32'(v[g].ovf));
          chk($sformatf("g%0d sum_g1", g), 32'(sum1), 32'(v[g].sum1));
          chk($sformatf("g%0d ovf_g1", g), 32'(ovf1), 32'(v[g].ovf1));
        end else chk($sformatf("g%0d early valid%0d", g, k), 32'(val0), 0);
        for (int h = 1; h < v[g].hold; h++) tick();
        done_in = 0;
        tick();
        if (k == 3) chk($sformatf("g%0d valid drop", g), 32'(val0), 0);
      end
    end
    send(16'h0005);
    send(16'h0005);
    chk("pre-clear cnt", 32'(cnt0), 2);
    done_in = 1;
    clear = 1;
    tick();
    clear = 0;
    done_in = 0;
    chk("clear cnt", 32'(cnt0), 0);
    chk("clear keeps sum", 32'(sum0), 32'h00FFFD);
    tick();
    for (int k = 0; k < 3; k++) send(16'h0005);
    done_in = 1;
    tick();
    chk("clear grp sum", 32'(sum0), 32'h000014);
    chk("clear grp valid", 32'(val0), 1);
    chk("clear drop", 32'(drop0), 0);
    done_in = 0;
    tick();
    send(16'h0001);
    send(16'hFFFF);
    send(16'hC080);
    done_in = 1;
    m_in = 16'h4000;
    tick();
    sum_ready = 0;
    done_in = 0;
    chk("bp first sum", 32'(sum0), 32'h000080);
    tick();
    for (int k = 0; k < 4; k++) send(16'h0002);
    chk("bp wait cnt", 32'(cnt0), 4);
    for (int k = 0; k < 3; k++) send(16'h0007);
    chk("bp drop", 32'(drop0), 3);
    chk("bp hold sum", 32'(sum0), 32'h000080);
    chk("bp hold valid", 32'(val0), 1);
    sum_ready = 1;
    tick();
    sum_ready = 0;
    chk("bp release sum", 32'(sum0), 32'h000008);
    chk("bp release valid", 32'(val0), 1);
    chk("bp release cnt", 32'(cnt0), 0);
    for (int k = 0; k < 4; k++) send(16'h0001);
    chk("rst pre cnt", 32'(cnt0), 4);
    chk("rst pre valid", 32'(val0), 1);
    rst = 1;
    tick();
    rst = 0;
    sum_ready = 1;
    chk("rst sum", 32'(sum0), 0);
    chk("rst ovf", 32'(ovf0), 0);
    chk("rst valid", 32'(val0), 0);
    chk("rst cnt", 32'(cnt0), 0);
    chk("rst drop", 32'(drop0), 0);
    for (int k = 0; k < 3; k++) send(16'h0002);
    done_in = 1;
    tick();
    done_in = 0;
    chk("post-rst sum", 32'(sum0), 32'h000008);
    chk("post-rst valid", 32'(val0), 1);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
